rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Round-robin arbiter that shares the 4-input 32-bit selection datapath among four requesters and drives a single downstream valid/ready port. It owns the 2-bit select, grants one requester at a time for a bounded burst, and rotates priority so every requester makes progress under full load. It sits directly in front of the 4:1 word multiplexer and replaces any static select logic.

## Interface
- WIDTH, 32, data word width of every input and of the output.
- MAX_BURST, 4, maximum beats per grant; legal range 1..15.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester request; bit i belongs to requester i.
- in1, in2, in3, in4  input  WIDTH each  requester data for requesters 0, 1, 2 and 3.
- out_ready  input  1  downstream accepts a beat when high together with out_valid.
- out_data  output  WIDTH  selected word: in1/in2/in3/in4 for sel = 0/1/2/3.
- out_valid  output  1  beat present on out_data.
- sel  output  2  registered index of the current owner.
- gnt  output  4  registered one-hot owner; all-zero when idle.
- ack  output  4  one-hot, combinational: gnt qualified by out_valid & out_ready.
- busy  output  1  high in state BURST.

## Operation
- State machine: IDLE, BURST.
- Internal registers: state, sel, gnt, count (4 bits), last (2 bits; index of the most recent owner).
- IDLE: when req is nonzero, choose the first set bit scanning last+1, last+2, last+3, last (mod 4). On the next edge: sel = winner, gnt = onehot(winner), last = winner, count = 0, state = BURST. When req = 0, hold all registers.
- BURST: out_valid = req[sel]. out_data = the sel-indexed input, combinational.
- Accepted beat (out_valid & out_ready): count increments. ack[sel] pulses in the same cycle.
- Exit from BURST to IDLE on the next edge when either of these holds:
  - an accepted beat makes count+1 = MAX_BURST;
  - req[sel] = 0 in the cycle (owner released).
- On exit, gnt clears to 0 and sel holds its value.
- Requester rules: hold data stable and req high until ack. Drop req to release.
- Requests from non-owners are ignored until the next IDLE arbitration.
- IDLE ignores out_ready. out_valid = 0 in IDLE.
- Count width rule: count never exceeds MAX_BURST-1 while in BURST.

## Timing
- Reset (asynchronous, immediate): state = IDLE, sel = 0, gnt = 0, count = 0, last = 3, so requester 0 has first priority. Outputs during reset: out_valid = 0, ack = 0, busy = 0, out_data = in1.
- Arbitration latency: a req rising in cycle N (in IDLE) gives gnt in N+1. The first beat can be accepted in N+1.
- Inter-burst gap: exactly one IDLE cycle between consecutive grants, including a re-grant to the same requester.
- Back-pressure: out_ready low stalls the burst indefinitely. count, sel and gnt hold. out_valid stays high while req[sel] is high.
- Simultaneous events:
  - The last beat is accepted and req[sel] drops in the same cycle: one exit, no extra beat.
  - All four requesting under continuous out_ready: grant order 0,1,2,3,0,...; each burst is MAX_BURST beats.
- Reset asserted mid-burst: immediate return to reset values. A partially sent burst is abandoned with no completion ack.
- Deassert rst_n synchronously to clk externally. The block adds no synchronizer.

## Test plan
- Reset: rst_n low with req = 4'b1111 -> sel = 0, gnt = 0, out_valid = 0, busy = 0. First edge after release -> gnt = 4'b0001.
- Single requester, continuous ready: req = 4'b0100, MAX_BURST = 4, data 32'hA5A5_0000+k.
  - Required: gnt = 4'b0100 one cycle after req.
  - Required: 4 acks on ack[2], out_data matches each word, then one IDLE cycle, then re-grant to 2.
- Full load fairness: req = 4'b1111 held, out_ready = 1 for 40 cycles -> owners 0,1,2,3,0,1,2,3; each exactly 4 beats with a 1-cycle gap.
- Back-pressure: owner 1 with out_ready low for 5 cycles mid-burst -> out_valid high and count frozen. Burst completes with a total of exactly MAX_BURST acks.
- Early release: owner 3 drops req after 2 accepted beats -> IDLE next cycle. Pending requester 0 is granted next (rotation after 3).
- Reset mid-burst: rst_n pulsed low at beat 2 of owner 2 -> outputs go to reset values in the same cycle. Next grant goes to requester 0 when req[0] is set.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// Bus between four requesters, the round-robin arbiter and one downstream port.
// The requester/downstream side uses the master modport; the arbiter uses slave.
interface rr_mux_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic [3:0]       req;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [1:0]       sel;
    logic [3:0]       gnt;
    logic [3:0]       ack;
    logic             busy;

    modport master (
        output req, in1, in2, in3, in4, out_ready,
        input  out_data, out_valid, sel, gnt, ack, busy
    );

    modport slave (
        input  req, in1, in2, in3, in4, out_ready,
        output out_data, out_valid, sel, gnt, ack, busy
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 word mux. One requester owns the
// output for a burst of at most MAX_BURST accepted beats; priority rotates past
// the most recent owner so every requester progresses under full load.
module rr_mux_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4   // legal range 1..15
) (
    input logic             clk,
    input logic             rst_n,
    rr_mux_arbiter_if.slave bus
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    // Count value of the final beat of a full burst.
    localparam logic [3:0] LastCount = 4'(MAX_BURST - 1);

    logic [0:0] state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] count_q, count_d;
    logic [1:0] last_q, last_d;

    logic [1:0]       win;
    logic             win_found;
    logic [1:0]       cand;
    logic             busy;
    logic             out_valid;
    logic             accept;
    logic [WIDTH-1:0] data_mux;

    assign busy      = (state_q == StBurst);
    assign out_valid = busy & bus.req[sel_q];
    assign accept    = out_valid & bus.out_ready;

    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    // gnt_q is zero outside a burst, so ack can only pulse for the owner.
    assign bus.ack       = gnt_q & {4{accept}};
    assign bus.out_data  = data_mux;

    // Word multiplexer driven by the registered select.
    always_comb begin
        data_mux = bus.in1;
        unique case (sel_q)
            2'd0: data_mux = bus.in1;
            2'd1: data_mux = bus.in2;
            2'd2: data_mux = bus.in3;
            2'd3: data_mux = bus.in4;
            default: data_mux = bus.in1;
        endcase
    end

    // Pick the first requester after the last owner, wrapping round to it last.
    always_comb begin
        win       = last_q;
        win_found = 1'b0;
        cand      = last_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!win_found && bus.req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    // Next-state: grant from IDLE, count beats and leave BURST on release or full burst.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        count_d = count_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    sel_d   = win;
                    gnt_d   = 4'b0001 << win;
                    last_d  = win;
                    count_d = 4'd0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (!bus.req[sel_q] || (accept && count_q == LastCount)) begin
                    gnt_d   = 4'b0000;
                    count_d = 4'd0;
                    state_d = StIdle;
                end else if (accept) begin
                    count_d = count_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
                count_d = 4'd0;
            end
        endcase
    end

    // State registers; reset leaves last = 3 so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            count_q <= 4'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: expected beats (owner, word) are queued as
// stimulus is driven and checked in order as acks appear.
module tb_rr_mux_arbiter;

    localparam int MB = 4;

    typedef struct packed {
        logic [1:0]  owner;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.WIDTH(32)) bus ();

    rr_mux_arbiter #(
        .WIDTH     (32),
        .MAX_BURST (MB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   beat[4]    = '{0, 0, 0, 0};
    int   pred[4]    = '{0, 0, 0, 0};
    int   ack_cnt[4] = '{0, 0, 0, 0};
    int   model_last = 3;
    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [31:0] word(input int r, input int k);
        logic [31:0] base;
        case (r)
            0:       base = 32'h1000_0000;
            1:       base = 32'h2000_0000;
            2:       base = 32'hA5A5_0000;
            default: base = 32'h4000_0000;
        endcase
        return base + 32'(k);
    endfunction

    // Each requester presents its next word; it advances once that word is acked.
    assign bus.in1 = word(0, beat[0]);
    assign bus.in2 = word(1, beat[1]);
    assign bus.in3 = word(2, beat[2]);
    assign bus.in4 = word(3, beat[3]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input int n);
        for (int j = 0; j < n; j++) begin
            sb.push_back('{owner: 2'(r), data: word(r, pred[r])});
            pred[r]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE with the owner's req set: one full burst then the idle gap.
    task automatic run_burst(input int owner);
        push(owner, MB);
        step();
        chk("burst_gnt", 32'(bus.gnt), 32'(4'b0001 << owner));
        chk("burst_sel", 32'(bus.sel), 32'(owner));
        model_last = owner;
        repeat (MB - 1) step();
        chk("burst_still_owned", 32'(bus.gnt), 32'(4'b0001 << owner));
        step();
        chk("gap_gnt", 32'(bus.gnt), 32'h0);
        chk("gap_busy", 32'(bus.busy), 32'h0);
        chk("gap_valid", 32'(bus.out_valid), 32'h0);
    endtask

    // Scoreboard: every ack must match the next queued beat.
    always @(negedge clk) begin
        if (bus.ack !== 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(bus.ack), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_owner", 32'(bus.ack), 32'(4'b0001 << mon_e.owner));
                chk("ack_data", bus.out_data, mon_e.data);
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i]) begin
                    beat[i]++;
                    ack_cnt[i]++;
                end
            end
        end
    end

    initial begin
        int a0;
        int owner;

        // Reset with all requesting and downstream stalled.
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_sel", 32'(bus.sel), 32'h0);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_data", bus.out_data, word(0, 0));
        step();
        rst_n = 1'b1;
        step();
        chk("rst_first_gnt", 32'(bus.gnt), 32'h1);
        chk("rst_first_valid", 32'(bus.out_valid), 32'h1);
        model_last = 0;
        bus.req = 4'b0000;
        step();
        chk("release_gnt", 32'(bus.gnt), 32'h0);
        chk("release_sel_hold", 32'(bus.sel), 32'h0);

        // Single requester 2, continuous ready, then a re-grant after one gap cycle.
        bus.req       = 4'b0100;
        bus.out_ready = 1'b1;
        #1;
        chk("idle_valid", 32'(bus.out_valid), 32'h0);
        run_burst(2);
        run_burst(2);
        bus.req = 4'b0000;
        chk("single_acks", 32'(ack_cnt[2]), 32'd8);
        step();

        // Full load: rotation continues from the last owner.
        bus.req = 4'b1111;
        for (int b = 0; b < 8; b++) begin
            owner = (model_last + 1) % 4;
            run_burst(owner);
        end
        bus.req = 4'b0000;
        step();

        // Back-pressure on owner 1.
        a0      = ack_cnt[1];
        bus.req = 4'b0010;
        push(1, MB);
        step();
        chk("bp_gnt", 32'(bus.gnt), 32'h2);
        model_last = 1;
        step();
        bus.out_ready = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_ack", 32'(bus.ack), 32'h0);
            chk("bp_gnt_hold", 32'(bus.gnt), 32'h2);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        step();
        chk("bp_last_beat_gnt", 32'(bus.gnt), 32'h2);
        step();
        chk("bp_exit_gnt", 32'(bus.gnt), 32'h0);
        chk("bp_acks", 32'(ack_cnt[1] - a0), 32'(MB));
        bus.req = 4'b0000;
        step();

        // Early release by owner 3 while requester 0 waits.
        bus.req = 4'b1001;
        push(3, 2);
        step();
        chk("er_gnt", 32'(bus.gnt), 32'h8);
        step();
        step();
        bus.req = 4'b0001;
        #1;
        chk("er_valid_drop", 32'(bus.out_valid), 32'h0);
        step();
        chk("er_idle_gnt", 32'(bus.gnt), 32'h0);
        chk("er_idle_busy", 32'(bus.busy), 32'h0);
        run_burst(0);
        bus.req = 4'b0000;
        step();

        // Reset in the middle of a burst from owner 2.
        bus.req = 4'b0100;
        push(2, 2);
        step();
        chk("mr_gnt", 32'(bus.gnt), 32'h4);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mr_sel", 32'(bus.sel), 32'h0);
        chk("mr_gnt_clr", 32'(bus.gnt), 32'h0);
        chk("mr_valid", 32'(bus.out_valid), 32'h0);
        chk("mr_busy", 32'(bus.busy), 32'h0);
        chk("mr_ack", 32'(bus.ack), 32'h0);
        chk("mr_data", bus.out_data, word(0, pred[0]));
        step();
        rst_n   = 1'b1;
        bus.req = 4'b0101;
        push(0, 1);
        step();
        chk("mr_regrant", 32'(bus.gnt), 32'h1);
        step();
        bus.req = 4'b0000;
        step();
        chk("mr_end_gnt", 32'(bus.gnt), 32'h0);
        step();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
